// File: rtl/rv32_pipe_pkg.sv
// Shared RV32 pipeline definitions: NOP control fields and the ID/EX payload layout.
package rv32_pipe_pkg;

  localparam int ID_EX_WIDTH = 103;

  localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;
  localparam logic [4:0]  ALU_NOP       = {1'b0, 4'd7};
  localparam logic [18:0] RB_NOP        = 19'd0;
  localparam logic [3:0]  BSHIFT_NOP    = 4'd0;
  localparam logic [4:0]  PC_CTRL_NOP   = {1'b1, 3'd0, 1'b1};
  localparam logic [1:0]  DATA_CTRL_NOP = {1'b0, 1'b1};

  // Low bit of each field, MSB-first order: code, pc, alu, rb, bshift, pc_ctrl, data_ctrl, spare
  localparam int SPARE_LSB     = 0;
  localparam int DATA_CTRL_LSB = 4;
  localparam int PC_CTRL_LSB   = 6;
  localparam int BSHIFT_LSB    = 11;
  localparam int RB_LSB        = 15;
  localparam int ALU_LSB       = 34;
  localparam int PC_LSB        = 39;
  localparam int CODE_LSB      = 71;

  localparam logic [ID_EX_WIDTH-1:0] ID_EX_NOP = {
    NOP_INSTR, 32'd0, ALU_NOP, RB_NOP, BSHIFT_NOP, PC_CTRL_NOP, DATA_CTRL_NOP, 4'd0
  };

  typedef struct packed {
    logic [31:0] code;
    logic [31:0] pc;
    logic [4:0]  alu;
    logic [18:0] rb;
    logic [3:0]  bshift;
    logic [4:0]  pc_ctrl;
    logic [1:0]  data_ctrl;
    logic [3:0]  spare;
  } id_ex_t;

  function automatic logic [ID_EX_WIDTH-1:0] pack_id_ex(input id_ex_t f);
    return f;
  endfunction

endpackage

// File: rtl/rv32_pipe_queue_if.sv
// Valid/ready handshake bundle between two pipeline stages, plus flush and occupancy.
interface rv32_pipe_queue_if #(
  parameter int WIDTH = 103,
  parameter int DEPTH = 2
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );
endinterface

// File: rtl/rv32_queue_mem.sv
// DEPTH x WIDTH storage for the pipe queue: one write port, asynchronous read, no reset.
module rv32_queue_mem #(
  parameter int WIDTH = 103,
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [PW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [PW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/rv32_pipe_queue.sv
// Parametrised pipeline-stage FIFO with valid/ready handshakes; shows the NOP payload when empty.
module rv32_pipe_queue
  import rv32_pipe_pkg::*;
#(
  parameter int                WIDTH     = 103,
  parameter int                DEPTH     = 2,
  parameter logic [WIDTH-1:0]  NOP_VALUE = ID_EX_NOP
) (
  input  logic                 clk,
  input  logic                 rst,
  rv32_pipe_queue_if.slave     q
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] head_data;
  logic             in_ready_w;
  logic             out_valid_w;
  logic             push;
  logic             pop;

  // Handshake outputs come only from count_reg, so out_ready never reaches in_ready.
  assign in_ready_w  = (count_reg < FULL_COUNT);
  assign out_valid_w = (count_reg != '0);
  assign push        = q.in_valid && in_ready_w;
  assign pop         = out_valid_w && q.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (q.flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + CW'(push) - CW'(pop);
    end
  end

  rv32_queue_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push && !q.flush),
    .wr_addr (wr_ptr_reg),
    .wr_data (q.in_data),
    .rd_addr (rd_ptr_reg),
    .rd_data (head_data)
  );

  assign q.in_ready  = in_ready_w;
  assign q.out_valid = out_valid_w;
  assign q.out_data  = out_valid_w ? head_data : NOP_VALUE;
  assign q.count     = count_reg;
endmodule

// File: tb/tb_rv32_pipe_queue.sv
// Randomised/directed bench for rv32_pipe_queue at DEPTH=2 and DEPTH=4 against a queue model.
module tb_rv32_pipe_queue;
  localparam int W = 103;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rv32_pipe_queue_if #(.WIDTH(W), .DEPTH(2)) a_if ();
  rv32_pipe_queue_if #(.WIDTH(W), .DEPTH(4)) b_if ();

  rv32_pipe_queue #(.WIDTH(W), .DEPTH(2)) dut_a (.clk(clk), .rst(rst), .q(a_if));
  rv32_pipe_queue #(.WIDTH(W), .DEPTH(4)) dut_b (.clk(clk), .rst(rst), .q(b_if));

  // NOP built field by field: code, pc, alu, rb, bshift, pc_ctrl, data_ctrl, spare
  localparam logic [W-1:0] NOP = {32'h0000_0013, 32'd0, 5'b00111, 19'd0, 4'd0, 5'b10001, 2'b01, 4'd0};

  int total = 0;
  int bad   = 0;

  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];
  logic [W-1:0] pb[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_pl();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[W-1:0];
  endfunction

  task automatic check_state(input int id, input string tag);
    int sz;
    logic [W-1:0] exp_d;
    if (id == 0) begin
      sz = qa.size();
      exp_d = (sz != 0) ? qa[0] : NOP;
      check({tag, ".a.count"}, 128'(a_if.count), 128'(sz));
      check({tag, ".a.out_valid"}, 128'(a_if.out_valid), 128'(sz != 0));
      check({tag, ".a.in_ready"}, 128'(a_if.in_ready), 128'(sz < 2));
      check({tag, ".a.out_data"}, 128'(a_if.out_data), 128'(exp_d));
    end else begin
      sz = qb.size();
      exp_d = (sz != 0) ? qb[0] : NOP;
      check({tag, ".b.count"}, 128'(b_if.count), 128'(sz));
      check({tag, ".b.out_valid"}, 128'(b_if.out_valid), 128'(sz != 0));
      check({tag, ".b.in_ready"}, 128'(b_if.in_ready), 128'(sz < 4));
      check({tag, ".b.out_data"}, 128'(b_if.out_data), 128'(exp_d));
    end
    $display("step %s dut=%0d occupancy=%0d", tag, id, sz);
  endtask

  task automatic idle_inputs();
    a_if.in_valid = 1'b0; a_if.in_data = '0; a_if.out_ready = 1'b0; a_if.flush = 1'b0;
    b_if.in_valid = 1'b0; b_if.in_data = '0; b_if.out_ready = 1'b0; b_if.flush = 1'b0;
  endtask

  // One clock cycle on one DUT; the model applies the queue rules at the edge.
  task automatic step(input int id, input bit iv, input logic [W-1:0] d,
                      input bit ordy, input bit fl, input string tag);
    int sz;
    bit do_push, do_pop;
    if (id == 0) begin
      a_if.in_valid = iv; a_if.in_data = d; a_if.out_ready = ordy; a_if.flush = fl;
      sz = qa.size();
      do_push = iv && (sz < 2);
    end else begin
      b_if.in_valid = iv; b_if.in_data = d; b_if.out_ready = ordy; b_if.flush = fl;
      sz = qb.size();
      do_push = iv && (sz < 4);
    end
    do_pop = (sz != 0) && ordy;
    @(posedge clk);
    if (id == 0) begin
      if (fl) qa.delete();
      else begin
        if (do_pop) void'(qa.pop_front());
        if (do_push) qa.push_back(d);
      end
    end else begin
      if (fl) qb.delete();
      else begin
        if (do_pop) pb.push_back(qb.pop_front());
        if (do_push) qb.push_back(d);
      end
    end
    #1;
    idle_inputs();
    check_state(id, tag);
  endtask

  logic [W-1:0] pay [5];
  logic [W-1:0] x_pl;

  initial begin
    idle_inputs();
    #2;
    check("reset.count", 128'(a_if.count), 128'(0));
    check("reset.out_data", 128'(a_if.out_data), 128'(NOP));
    check("reset.in_ready", 128'(b_if.in_ready), 128'(1));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_state(0, "post_reset");
    check_state(1, "post_reset");

    // Streaming on DEPTH=2: payloads 1..8 with constant out_ready
    for (int i = 1; i <= 8; i++) step(0, 1'b1, W'(i), 1'b1, 1'b0, "stream");
    step(0, 1'b0, '0, 1'b1, 1'b0, "stream_drain");

    // Empty output on DEPTH=2
    for (int i = 0; i < 5; i++) step(0, 1'b0, rand_pl(), 1'b1, 1'b0, "empty");

    // Backpressure on DEPTH=4
    for (int i = 0; i < 5; i++) pay[i] = rand_pl();
    pb.delete();
    for (int i = 0; i < 4; i++) step(1, 1'b1, pay[i], 1'b0, 1'b0, "bp_fill");
    check("bp.full_count", 128'(b_if.count), 128'(4));
    check("bp.full_ready", 128'(b_if.in_ready), 128'(0));
    step(1, 1'b1, pay[4], 1'b1, 1'b0, "bp_pop_full");
    check("bp.e_rejected", 128'(b_if.count), 128'(3));
    step(1, 1'b1, pay[4], 1'b1, 1'b0, "bp_accept_e");
    for (int i = 0; i < 5; i++) step(1, 1'b0, '0, 1'b1, 1'b0, "bp_drain");
    check("bp.pop_count", 128'(pb.size()), 128'(5));
    for (int i = 0; i < 5; i++)
      if (i < pb.size()) check("bp.order", 128'(pb[i]), 128'(pay[i]));

    // Wrap-around on DEPTH=4 with random stalls
    for (int i = 0; i < 24; i++)
      step(1, ($urandom % 4) != 0, rand_pl(), ($urandom % 3) != 0, 1'b0, "wrap");
    for (int i = 0; i < 4; i++) step(1, 1'b0, '0, 1'b1, 1'b0, "wrap_drain");

    // Flush priority with 3 entries held, simultaneous push and pop
    for (int i = 0; i < 3; i++) step(1, 1'b1, rand_pl(), 1'b0, 1'b0, "fl_fill");
    x_pl = rand_pl();
    step(1, 1'b1, x_pl, 1'b1, 1'b1, "flush");
    check("flush.code", 128'(b_if.out_data[102:71]), 128'(32'h0000_0013));
    check("flush.pc_ctrl", 128'(b_if.out_data[10:6]), 128'(5'b10001));
    for (int i = 0; i < 3; i++) begin
      step(1, 1'b0, '0, 1'b1, 1'b0, "post_flush");
      check("flush.no_x", 128'(b_if.out_data == x_pl), 128'(0));
    end

    // Asynchronous reset with 2 entries held on DEPTH=2
    step(0, 1'b1, rand_pl(), 1'b0, 1'b0, "rst_fill");
    step(0, 1'b1, rand_pl(), 1'b0, 1'b0, "rst_fill");
    check("rst.pre_count", 128'(a_if.count), 128'(2));
    #3;
    rst = 1'b1;
    #1;
    check("rst.async_count", 128'(a_if.count), 128'(0));
    check("rst.async_valid", 128'(a_if.out_valid), 128'(0));
    check("rst.async_data", 128'(a_if.out_data), 128'(NOP));
    check("rst.async_ready", 128'(a_if.in_ready), 128'(1));
    qa.delete();
    qb.delete();
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    check_state(0, "after_rst");
    step(0, 1'b1, W'(42), 1'b0, 1'b0, "after_rst_push");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
